// File: rtl/idex_pkg.sv
`default_nettype none
// ============================================================================
// Module   : idex_pkg
// Purpose  : Shared definitions for the ID/EX elastic stage register.
//            - control-bundle bit indices (fixed flags, then two ALU fields)
//            - control-bundle width derivation
//            - stage state encoding (state value == entries held)
// Revision : 1.0  initial release
// ============================================================================
package idex_pkg;

    // Single-bit control flags occupy the low seven bits of the bundle.
    localparam int c_CTRL_PCEN     = 0;
    localparam int c_CTRL_REGWRITE = 1;
    localparam int c_CTRL_ALU1SRC  = 2;
    localparam int c_CTRL_REGDST   = 3;
    localparam int c_CTRL_MEMWRITE = 4;
    localparam int c_CTRL_MEMREAD  = 5;
    localparam int c_CTRL_MEMTOREG = 6;

    // ALU1CNTRL starts right after the flags; ALU2CNTRL follows it.
    localparam int c_CTRL_ALU1CNTRL_LSB = 7;

    function automatic int alu2cntrl_lsb(input int alu_funct_bits);
        return c_CTRL_ALU1CNTRL_LSB + alu_funct_bits;
    endfunction

    function automatic int ctrl_width(input int alu_funct_bits);
        return 7 + 2 * alu_funct_bits;
    endfunction

    // Encoding equals the number of held entries, so it doubles as occupancy.
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/idex_payload_slot.sv
`default_nettype none
// ============================================================================
// Module   : idex_payload_slot
// Purpose  : One payload register of the ID/EX stage: load enable plus
//            synchronous clear (clear wins over load).
// Ports    : clk    - clock
//            rst    - synchronous active-high clear to all zeros
//            i_load - capture i_d at the next posedge
//            i_d    - payload in  [WIDTH-1:0]
//            o_q    - payload out [WIDTH-1:0]
// Revision : 1.0  initial release
// ============================================================================
module idex_payload_slot #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/idex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : idex_stage_reg
// Purpose  : Elastic ID/EX pipeline register with valid/ready handshake,
//            a one-entry skid buffer, synchronous flush and reset. Control
//            outputs are forced to zero whenever no valid entry is held.
// Ports    : CLK, RST            - clock, synchronous active-high reset
//            in_valid / in_ready - upstream handshake (decode side)
//            CtrlD, SrcD, RtD, RdD, SignImmD - incoming entry payload
//            flush               - drop held entries and the incoming one
//            out_valid/out_ready - downstream handshake (execute side)
//            Ctrl, Src, Rt, Rd, SignImm - head-entry payload
//            occupancy           - number of held entries (0..2)
// Revision : 1.0  initial release
// ============================================================================
module idex_stage_reg
    import idex_pkg::*;
#(
    parameter int BUS_WIDTH      = 32,
    parameter int ALU_FUNCT_BITS = 3,
    parameter int REGISTER       = 6,
    parameter int NUM_SRC        = 3,
    parameter int CTRL_W         = ctrl_width(ALU_FUNCT_BITS)
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTRL_W-1:0]            CtrlD,
    input  logic [NUM_SRC*BUS_WIDTH-1:0] SrcD,
    input  logic [REGISTER-1:0]          RtD,
    input  logic [REGISTER-1:0]          RdD,
    input  logic [BUS_WIDTH-1:0]         SignImmD,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTRL_W-1:0]            Ctrl,
    output logic [NUM_SRC*BUS_WIDTH-1:0] Src,
    output logic [REGISTER-1:0]          Rt,
    output logic [REGISTER-1:0]          Rd,
    output logic [BUS_WIDTH-1:0]         SignImm,
    output logic [1:0]                   occupancy
);

    localparam int c_PW = CTRL_W + NUM_SRC * BUS_WIDTH + 2 * REGISTER + BUS_WIDTH;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            w_accept;
    logic            w_drain;
    logic            w_main_load;
    logic            w_skid_load;
    logic            w_main_from_skid;
    logic [c_PW-1:0] w_in_pl;
    logic [c_PW-1:0] w_main_d;
    logic [c_PW-1:0] w_main_q;
    logic [c_PW-1:0] w_skid_q;
    logic [CTRL_W-1:0] w_main_ctrl;

    // in_ready is a function of state only (plus reset), so there is no
    // combinational path from out_ready back to decode.
    assign in_ready  = (r_state != c_ST_FULL) & ~RST;
    assign out_valid = (r_state != c_ST_EMPTY);
    assign occupancy = r_state;

    assign w_accept = in_valid & in_ready & ~flush;
    assign w_drain  = out_valid & out_ready;

    assign w_in_pl = {CtrlD, SrcD, RtD, RdD, SignImmD};

    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_skid_load      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            c_ST_EMPTY: begin
                if (w_accept) begin
                    w_main_load = 1'b1;
                    w_state_nxt = c_ST_ONE;
                end
            end
            c_ST_ONE: begin
                if (w_accept && w_drain) begin
                    w_main_load = 1'b1;
                end else if (w_accept) begin
                    w_skid_load = 1'b1;
                    w_state_nxt = c_ST_FULL;
                end else if (w_drain) begin
                    w_state_nxt = c_ST_EMPTY;
                end
            end
            c_ST_FULL: begin
                if (w_drain) begin
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_state_nxt      = c_ST_ONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_EMPTY;
            end
        endcase
        // A drain in the flush cycle has already been sampled downstream,
        // so only the resulting state matters here: nothing is retained.
        if (flush) begin
            w_state_nxt = c_ST_EMPTY;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : w_in_pl;

    idex_payload_slot #(
        .WIDTH (c_PW)
    ) u_main_slot (
        .clk    (CLK),
        .rst    (RST),
        .i_load (w_main_load),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    idex_payload_slot #(
        .WIDTH (c_PW)
    ) u_skid_slot (
        .clk    (CLK),
        .rst    (RST),
        .i_load (w_skid_load),
        .i_d    (w_in_pl),
        .o_q    (w_skid_q)
    );

    assign {w_main_ctrl, Src, Rt, Rd, SignImm} = w_main_q;
    assign Ctrl = out_valid ? w_main_ctrl : '0;

endmodule
`default_nettype wire

// File: tb/tb_idex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_idex_stage_reg
// Purpose  : Self-checking bench for idex_stage_reg (NUM_SRC=4, BUS_WIDTH=64).
//            A FIFO reference model of capacity two holds the expected
//            entries; a negedge monitor compares the DUT against its head.
// Revision : 1.0  initial release
// ============================================================================
module tb_idex_stage_reg;
    import idex_pkg::*;

    localparam int BW  = 64;
    localparam int NS  = 4;
    localparam int AFB = 3;
    localparam int RG  = 6;
    localparam int CW  = ctrl_width(AFB);

    typedef logic [NS*BW-1:0] wide_t;

    typedef struct {
        logic [CW-1:0]    ctrl;
        logic [NS*BW-1:0] src;
        logic [RG-1:0]    rt;
        logic [RG-1:0]    rd;
        logic [BW-1:0]    imm;
    } ent_t;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [CW-1:0]    CtrlD = '0;
    logic [NS*BW-1:0] SrcD = '0;
    logic [RG-1:0]    RtD = '0;
    logic [RG-1:0]    RdD = '0;
    logic [BW-1:0]    SignImmD = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CW-1:0]    Ctrl;
    logic [NS*BW-1:0] Src;
    logic [RG-1:0]    Rt;
    logic [RG-1:0]    Rd;
    logic [BW-1:0]    SignImm;
    logic [1:0]       occupancy;

    int   total = 0;
    int   bad = 0;
    int   dut_drains = 0;
    bit   started = 1'b0;
    bit   was_rst = 1'b0;
    ent_t exp_q[$];

    idex_stage_reg #(
        .BUS_WIDTH      (BW),
        .ALU_FUNCT_BITS (AFB),
        .REGISTER       (RG),
        .NUM_SRC        (NS),
        .CTRL_W         (CW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .CtrlD     (CtrlD),
        .SrcD      (SrcD),
        .RtD       (RtD),
        .RdD       (RdD),
        .SignImmD  (SignImmD),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Ctrl      (Ctrl),
        .Src       (Src),
        .Rt        (Rt),
        .Rd        (Rd),
        .SignImm   (SignImm),
        .occupancy (occupancy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input wide_t act, input wide_t req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // One cycle of stimulus; inputs change 1 time unit after the posedge.
    task automatic drive(input bit v, input bit ordy, input bit fl, input bit rs,
                         input logic [BW-1:0] imm);
        RST       = rs;
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        CtrlD     = CW'($urandom);
        for (int k = 0; k < NS * BW / 32; k++) SrcD[k*32 +: 32] = $urandom;
        RtD       = RG'($urandom);
        RdD       = RG'($urandom);
        SignImmD  = imm;
        @(posedge CLK);
        #1;
    endtask

    // Reference model: FIFO of at most two entries, updated at each posedge.
    initial begin
        ent_t e;
        ent_t dropped;
        bit   acc;
        forever begin
            @(posedge CLK);
            started = 1'b1;
            if (RST) begin
                exp_q.delete();
                was_rst = 1'b1;
            end else begin
                was_rst = 1'b0;
                acc = in_valid && !flush && (exp_q.size() < 2);
                if (exp_q.size() > 0 && out_ready) dropped = exp_q.pop_front();
                if (flush) exp_q.delete();
                if (acc) begin
                    e.ctrl = CtrlD;
                    e.src  = SrcD;
                    e.rt   = RtD;
                    e.rd   = RdD;
                    e.imm  = SignImmD;
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model head on every negedge.
    initial begin
        forever begin
            @(negedge CLK);
            if (started) begin
                chk("occupancy", wide_t'(occupancy), wide_t'(exp_q.size()));
                chk("out_valid", wide_t'(out_valid), wide_t'(exp_q.size() != 0));
                chk("in_ready", wide_t'(in_ready), wide_t'((exp_q.size() < 2) && !RST));
                if (exp_q.size() != 0) begin
                    chk("ctrl", wide_t'(Ctrl), wide_t'(exp_q[0].ctrl));
                    chk("src", Src, exp_q[0].src);
                    chk("rt", wide_t'(Rt), wide_t'(exp_q[0].rt));
                    chk("rd", wide_t'(Rd), wide_t'(exp_q[0].rd));
                    chk("signimm", wide_t'(SignImm), wide_t'(exp_q[0].imm));
                end else begin
                    chk("ctrl_idle", wide_t'(Ctrl), '0);
                end
                if (was_rst) begin
                    chk("rst_src", Src, '0);
                    chk("rst_rt_rd", wide_t'({Rt, Rd}), '0);
                    chk("rst_signimm", wide_t'(SignImm), '0);
                end
                if (out_valid && out_ready && !RST) dut_drains++;
            end
        end
    end

    initial begin
        int base;
        // Reset
        repeat (3) drive(0, 0, 0, 1, '0);

        // Streaming with out_ready high: one entry per cycle
        base = dut_drains;
        for (int i = 1; i <= 8; i++) drive(1, 1, 0, 0, BW'(i));
        repeat (2) drive(0, 1, 0, 0, '0);
        chk("stream_count", wide_t'(dut_drains - base), wide_t'(8));

        // Backpressure: fill both slots, hold, then release
        drive(1, 0, 0, 0, BW'(1));
        drive(1, 0, 0, 0, BW'(2));
        repeat (2) drive(1, 0, 0, 0, BW'(3));
        chk("bp_full_occ", wide_t'(occupancy), wide_t'(2));
        chk("bp_full_imm", wide_t'(SignImm), wide_t'(1));
        repeat (3) drive(0, 1, 0, 0, '0);

        // Flush while FULL with an incoming entry
        drive(1, 0, 0, 0, BW'(10));
        drive(1, 0, 0, 0, BW'(11));
        drive(1, 0, 1, 0, BW'(9));
        chk("flush_full_occ", wide_t'(occupancy), '0);
        chk("flush_memwrite", wide_t'(Ctrl[c_CTRL_MEMWRITE]), '0);
        chk("flush_regwrite", wide_t'(Ctrl[c_CTRL_REGWRITE]), '0);
        repeat (2) drive(0, 1, 0, 0, '0);

        // Flush in ONE with a drain and an incoming entry in the same cycle
        drive(1, 0, 0, 0, BW'(20));
        base = dut_drains;
        drive(1, 1, 1, 0, BW'(21));
        chk("flush_one_drain", wide_t'(dut_drains - base), wide_t'(1));
        chk("flush_one_occ", wide_t'(occupancy), '0);
        drive(0, 1, 0, 0, '0);

        // Reset while FULL with in_valid high
        drive(1, 0, 0, 0, BW'(30));
        drive(1, 0, 0, 0, BW'(31));
        drive(1, 1, 0, 1, BW'(32));
        drive(1, 1, 0, 1, BW'(33));
        drive(1, 0, 0, 0, 64'hDEAD_BEEF);
        drive(0, 0, 0, 0, '0);
        chk("post_rst_occ", wide_t'(occupancy), wide_t'(1));
        chk("post_rst_imm", wide_t'(SignImm), wide_t'(64'hDEAD_BEEF));
        repeat (2) drive(0, 1, 0, 0, '0);

        // Random valid/ready/flush/reset traffic
        for (int n = 0; n < 10000; n++) begin
            drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 65,
                  $urandom_range(0, 99) < 2, $urandom_range(0, 199) == 0,
                  {$urandom, $urandom});
        end
        repeat (3) drive(0, 1, 0, 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
